// File: rtl/mux4to1_reg_pkg.sv
// Shared constants for the store-data 4:1 selector: select encodings and
// the default data width.
package mux4to1_reg_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage : mux4to1_reg_pkg

// File: rtl/mux4_comb.sv
// Parameterised combinational 4:1 word selector. Pure mux, no state.
module mux4_comb
    import mux4to1_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic [WIDTH-1:0] data_C,
    input  logic [WIDTH-1:0] data_D,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] data_out
);

    // Select one of four candidates. The default arm is unreachable for a
    // known select, so synthesis reduces it to data_A. In a four-state
    // simulator (^sel ^ ^sel) is X for an unknown select, which turns every
    // output bit to X instead of silently returning data_A.
    always_comb begin
        data_out = data_A;
        case (sel)
            SEL_A:   data_out = data_A;
            SEL_B:   data_out = data_B;
            SEL_C:   data_out = data_C;
            SEL_D:   data_out = data_D;
            default: data_out = data_A ^ {WIDTH{(^sel) ^ (^sel)}};
        endcase
    end

endmodule : mux4_comb

// File: rtl/mux4to1_reg.sv
// Store-data 4:1 selector: combinational output plus a one-stage capture
// register (word, select and valid flag) for pipelined consumers.
module mux4to1_reg
    import mux4to1_reg_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic [WIDTH-1:0] data_C,
    input  logic [WIDTH-1:0] data_D,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_out_q,
    output logic             valid_q,
    output logic [1:0]       sel_q
);

    logic [WIDTH-1:0] data_q_reg;
    logic [1:0]       sel_q_reg;
    logic             valid_q_reg;

    mux4_comb #(
        .WIDTH (WIDTH)
    ) u_mux (
        .data_A   (data_A),
        .data_B   (data_B),
        .data_C   (data_C),
        .data_D   (data_D),
        .sel      (sel),
        .data_out (data_out)
    );

    // Capture the selected word when enabled; valid pulses only on cycles
    // that actually captured, while word and select hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q_reg  <= RESET_VALUE;
            sel_q_reg   <= SEL_A;
            valid_q_reg <= 1'b0;
        end else if (en) begin
            data_q_reg  <= data_out;
            sel_q_reg   <= sel;
            valid_q_reg <= 1'b1;
        end else begin
            valid_q_reg <= 1'b0;
        end
    end

    assign data_out_q = data_q_reg;
    assign sel_q      = sel_q_reg;
    assign valid_q    = valid_q_reg;

endmodule : mux4to1_reg

// File: tb/tb_mux4to1_reg.sv
// Directed self-checking bench for mux4to1_reg.
module tb_mux4to1_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clk_run = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_A = '0;
    logic [W-1:0] data_B = '0;
    logic [W-1:0] data_C = '0;
    logic [W-1:0] data_D = '0;
    logic [3:0]   sel_wide = '0;
    logic         en = 1'b0;
    logic [W-1:0] data_out;
    logic [W-1:0] data_out_q;
    logic         valid_q;
    logic [1:0]   sel_q;

    int checks = 0;
    int failures = 0;

    mux4to1_reg #(
        .WIDTH       (W),
        .RESET_VALUE ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_A     (data_A),
        .data_B     (data_B),
        .data_C     (data_C),
        .data_D     (data_D),
        .sel        (sel_wide[1:0]),
        .en         (en),
        .data_out   (data_out),
        .data_out_q (data_out_q),
        .valid_q    (valid_q),
        .sel_q      (sel_q)
    );

    // Clock only toggles once the bench enables it.
    initial begin
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Combinational path, no clock running
        data_A = 32'hFFFF_FFFF;
        data_B = 32'hAAAA_AAAA;
        data_C = 32'hBBBB_BBBB;
        data_D = 32'hCCCC_CCCC;
        sel_wide = 4'd0; #100; check("comb_sel0", data_out, 32'hFFFF_FFFF);
        sel_wide = 4'd1; #100; check("comb_sel1", data_out, 32'hAAAA_AAAA);
        sel_wide = 4'd2; #100; check("comb_sel2", data_out, 32'hBBBB_BBBB);
        sel_wide = 4'd3; #100; check("comb_sel3", data_out, 32'hCCCC_CCCC);

        // Wide select values truncated to 2 bits by the connection
        sel_wide = 4'd10; #100; check("trunc_10", data_out, 32'hBBBB_BBBB);
        sel_wide = 4'd11; #100; check("trunc_11", data_out, 32'hCCCC_CCCC);

        // Reset for two cycles while en is high
        rst = 1'b1; en = 1'b1; sel_wide = 4'd2;
        clk_run = 1'b1;
        tick();
        check("rst1_q", data_out_q, 32'h0);
        check("rst1_valid", {31'b0, valid_q}, 32'h0);
        check("rst1_selq", {30'b0, sel_q}, 32'h0);
        sel_wide = 4'd1;
        tick();
        check("rst2_q", data_out_q, 32'h0);
        check("rst2_valid", {31'b0, valid_q}, 32'h0);
        check("rst2_selq", {30'b0, sel_q}, 32'h0);
        check("rst2_comb", data_out, 32'hAAAA_AAAA);

        // First capture after reset release
        rst = 1'b0; en = 1'b1; sel_wide = 4'd1;
        tick();
        check("cap_q", data_out_q, 32'hAAAA_AAAA);
        check("cap_selq", {30'b0, sel_q}, 32'h1);
        check("cap_valid", {31'b0, valid_q}, 32'h1);

        // Hold with en low
        en = 1'b0; sel_wide = 4'd3;
        #1; check("hold_comb", data_out, 32'hCCCC_CCCC);
        tick();
        check("hold_q", data_out_q, 32'hAAAA_AAAA);
        check("hold_valid", {31'b0, valid_q}, 32'h0);
        check("hold_selq", {30'b0, sel_q}, 32'h1);

        // Back-to-back stream
        en = 1'b1;
        sel_wide = 4'd0; tick();
        check("strm0_q", data_out_q, 32'hFFFF_FFFF);
        check("strm0_valid", {31'b0, valid_q}, 32'h1);
        sel_wide = 4'd1; tick();
        check("strm1_q", data_out_q, 32'hAAAA_AAAA);
        check("strm1_valid", {31'b0, valid_q}, 32'h1);
        sel_wide = 4'd2; tick();
        check("strm2_q", data_out_q, 32'hBBBB_BBBB);
        check("strm2_selq", {30'b0, sel_q}, 32'h2);
        sel_wide = 4'd3; tick();
        check("strm3_q", data_out_q, 32'hCCCC_CCCC);
        check("strm3_valid", {31'b0, valid_q}, 32'h1);

        // Input changes late in the cycle: value present at the edge is stored
        sel_wide = 4'd1;
        @(negedge clk);
        data_B = 32'h1234_5678;
        tick();
        check("late_q", data_out_q, 32'h1234_5678);
        data_B = 32'hAAAA_AAAA;

        // Reset mid-stream
        rst = 1'b1; en = 1'b1; sel_wide = 4'd2;
        tick();
        check("mid_rst_q", data_out_q, 32'h0);
        check("mid_rst_valid", {31'b0, valid_q}, 32'h0);
        check("mid_rst_comb", data_out, 32'hBBBB_BBBB);
        rst = 1'b0;
        tick();
        check("resume_q", data_out_q, 32'hBBBB_BBBB);
        check("resume_valid", {31'b0, valid_q}, 32'h1);
        check("resume_selq", {30'b0, sel_q}, 32'h2);

        clk_run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux4to1_reg
